// File: rtl/button_matrix_pkg.sv
// Shared types and helpers for the button matrix scanner.
// Key index convention: idx = row * CWIDTH + col (same as the combinational decoder).
package button_matrix_pkg;

    // Frame classification result
    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_KEY   = 2'd1,
        CLS_MULTI = 2'd2
    } cls_t;

    // Width of a linear key index; a 1x1 matrix still gets a 1-bit index
    function automatic int unsigned idx_width(input int unsigned rw, input int unsigned cw);
        return (rw * cw > 1) ? $clog2(rw * cw) : 1;
    endfunction

endpackage

// File: rtl/key_frame_classifier.sv
// Classifies a full-frame key snapshot as none / single key / multi-press.
module key_frame_classifier
    import button_matrix_pkg::*;
#(
    parameter int unsigned RWIDTH = 4,
    parameter int unsigned CWIDTH = 4,
    localparam int unsigned NKEYS = RWIDTH * CWIDTH,
    localparam int unsigned IW    = idx_width(RWIDTH, CWIDTH)
) (
    input  logic [NKEYS-1:0] snapshot,
    output cls_t             cls,
    output logic [IW-1:0]    cls_idx
);

    logic [1:0] cnt;

    // Saturating popcount (0, 1, >=2) plus lowest-set-bit priority encode
    always_comb begin
        cnt     = 2'd0;
        cls_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (snapshot[i]) begin
                cls_idx = IW'(i);
                if (cnt != 2'd2) begin
                    cnt = cnt + 2'd1;
                end
            end
        end
    end

    // Map popcount to classification
    always_comb begin
        case (cnt)
            2'd0:    cls = CLS_NONE;
            2'd1:    cls = CLS_KEY;
            default: cls = CLS_MULTI;
        endcase
    end

endmodule

// File: rtl/button_matrix_scanner.sv
// Column-scanning button matrix reader with frame-level debounce and press/release events.
module button_matrix_scanner
    import button_matrix_pkg::*;
#(
    parameter int unsigned RWIDTH          = 4,
    parameter int unsigned CWIDTH          = 4,
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    localparam int unsigned NKEYS = RWIDTH * CWIDTH,
    localparam int unsigned IW    = idx_width(RWIDTH, CWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RWIDTH-1:0] row_in,
    output logic [CWIDTH-1:0] col_drive,
    output logic [IW-1:0]     key_idx,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              multi_press,
    output logic              frame_tick
);

    localparam int unsigned DW  = $clog2(SCAN_DIV);
    localparam int unsigned CCW = (CWIDTH > 1) ? $clog2(CWIDTH) : 1;
    localparam int unsigned SW  = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0]  DwellLast = DW'(SCAN_DIV - 1);
    localparam logic [CCW-1:0] ColLast   = CCW'(CWIDTH - 1);
    localparam logic [SW-1:0]  StableMax = SW'(DEBOUNCE_FRAMES);

    logic [RWIDTH-1:0] row_meta_q, row_sync_q;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [CCW-1:0]    col_q, col_d;
    logic [NKEYS-1:0]  snapshot_q, snapshot_d;
    logic              frame_tick_q, frame_tick_d;
    cls_t              prev_cls_q, prev_cls_d;
    logic [IW-1:0]     prev_idx_q, prev_idx_d;
    logic [SW-1:0]     stable_cnt_q, stable_cnt_d;
    cls_t              com_cls_q, com_cls_d;
    logic [IW-1:0]     key_idx_q, key_idx_d;
    logic              key_valid_q, key_valid_d;
    logic              key_release_q, key_release_d;

    cls_t              cls;
    logic [IW-1:0]     cls_idx;
    logic              same_as_prev;
    logic              differs_from_com;

    key_frame_classifier #(
        .RWIDTH (RWIDTH),
        .CWIDTH (CWIDTH)
    ) u_classifier (
        .snapshot (snapshot_q),
        .cls      (cls),
        .cls_idx  (cls_idx)
    );

    // Drive the current column only while scanning is enabled
    always_comb begin
        col_drive = '0;
        for (int c = 0; c < int'(CWIDTH); c++) begin
            col_drive[c] = en && (int'(col_q) == c);
        end
    end

    // Compare the finished frame against the previous frame and the committed state
    always_comb begin
        same_as_prev     = (cls == prev_cls_q) && ((cls != CLS_KEY) || (cls_idx == prev_idx_q));
        differs_from_com = (cls != com_cls_q) || ((cls == CLS_KEY) && (cls_idx != key_idx_q));
    end

    // Scan sequencing, snapshot capture, debounce and commit next-state
    always_comb begin
        dwell_d       = dwell_q;
        col_d         = col_q;
        snapshot_d    = snapshot_q;
        frame_tick_d  = 1'b0;
        prev_cls_d    = prev_cls_q;
        prev_idx_d    = prev_idx_q;
        stable_cnt_d  = stable_cnt_q;
        com_cls_d     = com_cls_q;
        key_idx_d     = key_idx_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;

        if (!en) begin
            // Committed state and level outputs are deliberately left alone
            dwell_d      = '0;
            col_d        = '0;
            snapshot_d   = '0;
            stable_cnt_d = '0;
        end else begin
            if (dwell_q == DwellLast) begin
                dwell_d = '0;
                for (int k = 0; k < int'(NKEYS); k++) begin
                    if ((k % int'(CWIDTH)) == int'(col_q)) begin
                        snapshot_d[k] = row_sync_q[k / int'(CWIDTH)];
                    end
                end
                if (col_q == ColLast) begin
                    col_d        = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    col_d = col_q + CCW'(1);
                end
            end else begin
                dwell_d = dwell_q + DW'(1);
            end

            // snapshot_q holds a complete frame during the frame_tick cycle
            if (frame_tick_q) begin
                if (same_as_prev) begin
                    stable_cnt_d = (stable_cnt_q == StableMax) ? stable_cnt_q
                                                               : stable_cnt_q + SW'(1);
                end else begin
                    stable_cnt_d = SW'(1);
                end
                prev_cls_d = cls;
                prev_idx_d = cls_idx;

                if ((stable_cnt_d == StableMax) && differs_from_com) begin
                    com_cls_d = cls;
                    case (cls)
                        CLS_KEY: begin
                            key_valid_d = 1'b1;
                            key_idx_d   = cls_idx;
                        end
                        // Leaving a held key (to none or multi) reports its release
                        default: key_release_d = (com_cls_q == CLS_KEY);
                    endcase
                end
            end
        end
    end

    // State registers, including the 2-flop row synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q    <= '0;
            row_sync_q    <= '0;
            dwell_q       <= '0;
            col_q         <= '0;
            snapshot_q    <= '0;
            frame_tick_q  <= 1'b0;
            prev_cls_q    <= CLS_NONE;
            prev_idx_q    <= '0;
            stable_cnt_q  <= '0;
            com_cls_q     <= CLS_NONE;
            key_idx_q     <= '0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            row_meta_q    <= row_in;
            row_sync_q    <= row_meta_q;
            dwell_q       <= dwell_d;
            col_q         <= col_d;
            snapshot_q    <= snapshot_d;
            frame_tick_q  <= frame_tick_d;
            prev_cls_q    <= prev_cls_d;
            prev_idx_q    <= prev_idx_d;
            stable_cnt_q  <= stable_cnt_d;
            com_cls_q     <= com_cls_d;
            key_idx_q     <= key_idx_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
        end
    end

    // Outputs come straight from registered state
    always_comb begin
        key_idx     = key_idx_q;
        key_valid   = key_valid_q;
        key_release = key_release_q;
        key_held    = (com_cls_q == CLS_KEY);
        multi_press = (com_cls_q == CLS_MULTI);
        frame_tick  = frame_tick_q;
    end

endmodule

// File: tb/tb_button_matrix_scanner.sv
// Scoreboard bench for button_matrix_scanner: directed key patterns on an ideal 4x4 matrix.
module tb_button_matrix_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] key_idx;
    logic       key_valid;
    logic       key_release;
    logic       key_held;
    logic       multi_press;
    logic       frame_tick;

    logic [15:0] pressed;

    typedef struct packed {
        logic       rel;
        logic [3:0] idx;
        logic       held;
        logic       multi;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    button_matrix_scanner #(
        .RWIDTH          (4),
        .CWIDTH          (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .row_in      (row_in),
        .col_drive   (col_drive),
        .key_idx     (key_idx),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held),
        .multi_press (multi_press),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Ideal matrix: a closed key connects its driven column to its row
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = |(pressed[r*4 +: 4] & col_drive);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic rel, input logic [3:0] idx, input logic held,
                        input logic multi);
        ev_t e;
        e.rel   = rel;
        e.idx   = idx;
        e.held  = held;
        e.multi = multi;
        sb.push_back(e);
    endtask

    task automatic wait_tick();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_tick && t < 200);
        if (!frame_tick) begin
            checks++;
            errors++;
            $display("FAIL frame_tick_timeout: got 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Monitor: every event pulse must match the head of the scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (key_valid || key_release)) begin
                chk("valid_release_exclusive", {31'd0, key_valid && key_release}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got valid=%0b release=%0b idx=%0d expected none",
                             key_valid, key_release, key_idx);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_release", {31'd0, key_release}, {31'd0, e.rel});
                    chk("event_key_idx", {28'd0, key_idx}, {28'd0, e.idx});
                    chk("event_key_held", {31'd0, key_held}, {31'd0, e.held});
                    chk("event_multi_press", {31'd0, multi_press}, {31'd0, e.multi});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        logic bad;

        rst_n   = 1'b0;
        en      = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_col_drive", {28'd0, col_drive}, 32'h1);
        chk("reset_key_idx", {28'd0, key_idx}, 32'h0);
        chk("reset_pulses", {30'd0, key_valid, key_release}, 32'h0);
        chk("reset_levels", {30'd0, key_held, multi_press}, 32'h0);
        chk("reset_frame_tick", {31'd0, frame_tick}, 32'h0);

        // Column sequence: 4 cycles per column, first tick after 16 cycles
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (col_drive !== 4'(1 << (i / 4)) || frame_tick !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("col_drive_sequence", {31'd0, bad}, 32'd0);
        chk("first_frame_tick", {31'd0, frame_tick}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        chk("frame_period", n, 16);
        chk("idle_no_levels", {30'd0, key_held, multi_press}, 32'd0);

        // Press key 6 (row1/col2): commit after 2nd stable frame, no repeat
        push(1'b0, 4'd6, 1'b1, 1'b0);
        pressed = 16'h0040;
        wait_ticks(4);
        chk("held_after_press", {31'd0, key_held}, 32'd1);
        chk("sb_empty_press", sb.size(), 0);

        // Release key 6
        push(1'b1, 4'd6, 1'b0, 1'b0);
        pressed = '0;
        wait_ticks(3);
        chk("released_level", {31'd0, key_held}, 32'd0);
        chk("released_idx", {28'd0, key_idx}, 32'd6);
        chk("sb_empty_release", sb.size(), 0);

        // Key 6 on alternate frames never stabilises
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            wait_tick();
        end
        pressed = '0;
        wait_ticks(3);
        chk("bounce_no_hold", {31'd0, key_held}, 32'd0);

        // Hold 6, add 9 (row2/col1) -> multi, drop 6 -> key 9, then back to 6
        push(1'b0, 4'd6, 1'b1, 1'b0);
        pressed = 16'h0040;
        wait_ticks(3);
        push(1'b1, 4'd6, 1'b0, 1'b1);
        pressed = 16'h0240;
        wait_ticks(3);
        chk("multi_level", {30'd0, multi_press, key_held}, 32'h2);
        push(1'b0, 4'd9, 1'b1, 1'b0);
        pressed = 16'h0200;
        wait_ticks(3);
        chk("multi_to_key_levels", {30'd0, multi_press, key_held}, 32'h1);
        push(1'b0, 4'd6, 1'b1, 1'b0);
        pressed = 16'h0040;
        wait_ticks(3);
        chk("key_to_key_idx", {28'd0, key_idx}, 32'd6);
        chk("sb_empty_multi", sb.size(), 0);

        // Asynchronous reset mid-frame while key 6 is held
        wait_tick();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_levels", {30'd0, key_held, multi_press}, 32'd0);
        chk("midreset_idx", {28'd0, key_idx}, 32'd0);
        chk("midreset_col_drive", {28'd0, col_drive}, 32'h1);
        push(1'b0, 4'd6, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(3);
        chk("sb_empty_after_reset", sb.size(), 0);

        // en low while key held: no drive, no ticks, levels hold
        wait_tick();
        repeat (3) @(negedge clk);
        en = 1'b0;
        #1;
        chk("en_low_col_drive", {28'd0, col_drive}, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_drive !== 4'h0 || frame_tick !== 1'b0) bad = 1'b1;
        end
        chk("en_low_quiet", {31'd0, bad}, 32'd0);
        chk("en_low_held", {31'd0, key_held}, 32'd1);
        chk("en_low_idx", {28'd0, key_idx}, 32'd6);
        en = 1'b1;
        #1;
        chk("en_restart_col0", {28'd0, col_drive}, 32'h1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        chk("en_restart_tick_latency", n, 16);
        wait_ticks(3);
        chk("en_restart_still_held", {31'd0, key_held}, 32'd1);

        // Final release
        push(1'b1, 4'd6, 1'b0, 1'b0);
        pressed = '0;
        wait_ticks(3);
        chk("sb_empty_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
